serial_comparator: RTL and testbench

- Bit-serial counterpart of the team's 4-bit parallel magnitude comparator.
- Operands A and B arrive one bit pair per accepted cycle from a serial link or shift chain, instead of as parallel buses.
- After WIDTH accepted bit pairs, the block reports greater / less / equal with a one-cycle done strobe.
- Used where operands are already serialised and a full parallel compare is too wide.

---
 rtl/comparator_pkg.sv | 27 ++
 rtl/serial_comparator.sv | 102 ++++++++++
 tb/tb_serial_comparator.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/comparator_pkg.sv
// Types shared by the parallel and serial magnitude comparators.
// FSM state encoding, result struct and a helper that turns decision flags into a result.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    typedef struct packed {
        logic g;
        logic l;
        logic eq;
    } cmp_result_t;

    localparam cmp_result_t CMP_CLEAR = '{g: 1'b0, l: 1'b0, eq: 1'b0};

    function automatic cmp_result_t cmp_resolve(input logic gt, input logic lt);
        cmp_result_t r;
        r.g  = gt;
        r.l  = lt;
        r.eq = !(gt | lt);
        return r;
    endfunction

endpackage

// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator: WIDTH accepted bit pairs -> g/l/eq with a one-cycle done strobe.
// Latency: done one cycle after the last accepted pair; bit_valid=0 stalls with no state change.
module serial_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic g,
    output logic l,
    output logic eq
);

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);

    cmp_state_t    state;
    logic [CW-1:0] cnt;
    logic          gt_q;
    logic          lt_q;
    logic          busy_q;
    logic          done_q;
    cmp_result_t   res_q;

    logic          gt_nxt;
    logic          lt_nxt;
    logic          last_pair;

    // MSB-first: the first difference is final. LSB-first: later differences are
    // more significant, so each one overwrites the previous decision.
    always_comb begin
        gt_nxt    = gt_q;
        lt_nxt    = lt_q;
        last_pair = (cnt == LAST_IDX);
        if ((a_bit ^ b_bit) && (!MSB_FIRST || !(gt_q || lt_q))) begin
            gt_nxt = a_bit;
            lt_nxt = b_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            gt_q   <= 1'b0;
            lt_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            res_q  <= CMP_CLEAR;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                        cnt    <= '0;
                        gt_q   <= 1'b0;
                        lt_q   <= 1'b0;
                        res_q  <= CMP_CLEAR;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    if (bit_valid) begin
                        gt_q <= gt_nxt;
                        lt_q <= lt_nxt;
                        if (last_pair) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            cnt    <= '0;
                            res_q  <= cmp_resolve(gt_nxt, lt_nxt);
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign g    = res_q.g;
    assign l    = res_q.l;
    assign eq   = res_q.eq;

endmodule

// File: tb/tb_serial_comparator.sv
// Randomized self-checking bench for serial_comparator (MSB-first, LSB-first and WIDTH=1 instances).
module tb_serial_comparator;

    logic clk = 1'b0;
    logic rst_n;
    logic start, bit_valid, a_bit, b_bit;
    logic w1_start, w1_valid;

    logic m_busy, m_done, m_g, m_l, m_eq;
    logic s_busy, s_done, s_g, s_l, s_eq;
    logic o_busy, o_done, o_g, o_l, o_eq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] held_m, held_s, held_o;
    bit         in_run;

    always #5 clk = ~clk;

    serial_comparator #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
        .a_bit(a_bit), .b_bit(b_bit), .busy(m_busy), .done(m_done),
        .g(m_g), .l(m_l), .eq(m_eq));

    serial_comparator #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
        .a_bit(a_bit), .b_bit(b_bit), .busy(s_busy), .done(s_done),
        .g(s_g), .l(s_l), .eq(s_eq));

    serial_comparator #(.WIDTH(1), .MSB_FIRST(1'b1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .start(w1_start), .bit_valid(w1_valid),
        .a_bit(a_bit), .b_bit(b_bit), .busy(o_busy), .done(o_done),
        .g(o_g), .l(o_l), .eq(o_eq));

    // Reference: plain integer magnitude compare, result as {g,l,eq}.
    function automatic logic [2:0] ref_cmp(input int a, input int b);
        return {a > b, a < b, a == b};
    endfunction

    function automatic logic [3:0] rev4(input logic [3:0] v);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = v[3-i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs as {busy,done,g,l,eq}
    task automatic check_run(input string tag);
        check({"m_run_", tag}, {m_busy, m_done, m_g, m_l, m_eq}, 5'b10000);
        check({"s_run_", tag}, {s_busy, s_done, s_g, s_l, s_eq}, 5'b10000);
    endtask

    task automatic check_idle(input string tag);
        check({"m_idle_", tag}, {m_busy, m_done, m_g, m_l, m_eq}, {2'b00, held_m});
        check({"s_idle_", tag}, {s_busy, s_done, s_g, s_l, s_eq}, {2'b00, held_s});
    endtask

    task automatic check_done(input string tag);
        check({"m_done_", tag}, {m_busy, m_done, m_g, m_l, m_eq}, {2'b01, held_m});
        check({"s_done_", tag}, {s_busy, s_done, s_g, s_l, s_eq}, {2'b01, held_s});
    endtask

    // The pair presented alongside start must not be consumed.
    task automatic begin_cmp();
        start     = 1'b1;
        bit_valid = 1'b1;
        a_bit     = 1'($urandom);
        b_bit     = 1'($urandom);
        tick();
        start = 1'b0;
        check_run("start");
        in_run = 1'b1;
    endtask

    // sa/sb hold the bits in stream order: sa[3] is sent first.
    task automatic feed(input logic [3:0] sa, input logic [3:0] sb, input int stall_at,
                        input int stall_len, input bit noisy, input bit chain);
        for (int i = 0; i < 4; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    bit_valid = 1'b0;
                    start     = noisy ? 1'($urandom) : 1'b0;
                    a_bit     = 1'($urandom);
                    b_bit     = 1'($urandom);
                    tick();
                    check_run("stall");
                end
            end
            start     = noisy ? 1'($urandom) : 1'b0;
            bit_valid = 1'b1;
            a_bit     = sa[3-i];
            b_bit     = sb[3-i];
            tick();
            if (i < 3) begin
                check_run("pair");
            end else begin
                held_m = ref_cmp(int'(sa), int'(sb));
                held_s = ref_cmp(int'(rev4(sa)), int'(rev4(sb)));
                check_done("result");
            end
        end
        start     = chain;
        bit_valid = 1'($urandom);
        a_bit     = 1'($urandom);
        b_bit     = 1'($urandom);
        tick();
        start = 1'b0;
        if (chain) check_run("chain");
        else       check_idle("after");
        in_run = chain;
    endtask

    task automatic idle_noise(input int n);
        for (int k = 0; k < n; k++) begin
            start     = 1'b0;
            bit_valid = 1'b1;
            a_bit     = 1'($urandom);
            b_bit     = 1'($urandom);
            tick();
            check_idle("noise");
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
        w1_start = 1'b0; w1_valid = 1'b0;
        held_m = 3'b000; held_s = 3'b000; held_o = 3'b000; in_run = 1'b0;
        tick();
        check("reset_m", {m_busy, m_done, m_g, m_l, m_eq}, 5'b00000);
        check("reset_s", {s_busy, s_done, s_g, s_l, s_eq}, 5'b00000);
        check("reset_w1", {o_busy, o_done, o_g, o_l, o_eq}, 5'b00000);
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("post_reset");

        // Directed back-to-back chain: 10v11, 10v8, 10v10, 0v1
        begin_cmp();
        feed(4'd10, 4'd11, -1, 0, 1'b0, 1'b1);
        feed(4'd10, 4'd8,  -1, 0, 1'b0, 1'b1);
        feed(4'd10, 4'd10, -1, 0, 1'b0, 1'b1);
        feed(4'd0,  4'd1,  -1, 0, 1'b0, 1'b0);

        // Stall for 3 cycles after the 2nd pair
        begin_cmp();
        feed(4'd10, 4'd11, 2, 3, 1'b0, 1'b0);

        // LSB-first streams: A=10 vs B=8, then A=1 vs B=8
        begin_cmp();
        feed(rev4(4'd10), rev4(4'd8), -1, 0, 1'b0, 1'b0);
        begin_cmp();
        feed(rev4(4'd1), rev4(4'd8), -1, 0, 1'b0, 1'b0);

        // Spurious bit_valid in IDLE and start/bit noise during RUN
        idle_noise(3);
        begin_cmp();
        feed(4'd10, 4'd11, 1, 2, 1'b1, 1'b0);

        // Asynchronous reset mid-comparison
        begin_cmp();
        for (int i = 0; i < 2; i++) begin
            bit_valid = 1'b1;
            a_bit = 1'(4'd10 >> (3 - i));
            b_bit = 1'(4'd11 >> (3 - i));
            tick();
            check_run("pre_reset");
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_m", {m_busy, m_done, m_g, m_l, m_eq}, 5'b00000);
        check("arst_s", {s_busy, s_done, s_g, s_l, s_eq}, 5'b00000);
        held_m = 3'b000; held_s = 3'b000; in_run = 1'b0;
        bit_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("arst_release");
        begin_cmp();
        feed(4'd10, 4'd8, -1, 0, 1'b0, 1'b0);

        // Randomized comparisons with stalls, noise and chaining
        for (int t = 0; t < 40; t++) begin
            logic [3:0] ra, rb;
            ra = 4'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom);
            if (!in_run) begin
                if ($urandom_range(0, 1) == 1) idle_noise(1);
                begin_cmp();
            end
            feed(ra, rb, $urandom_range(0, 4), $urandom_range(0, 3),
                 1'($urandom), (t < 39) ? 1'($urandom) : 1'b0);
        end

        // WIDTH=1 instance: done follows the first accepted pair
        bit_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            logic [1:0] ab;
            ab = 2'(c);
            w1_start = 1'b1;
            w1_valid = 1'b1;
            a_bit = ~ab[1];
            b_bit = ~ab[0];
            tick();
            w1_start = 1'b0;
            check("w1_run", {o_busy, o_done, o_g, o_l, o_eq}, 5'b10000);
            a_bit = ab[1];
            b_bit = ab[0];
            tick();
            held_o = ref_cmp(int'(ab[1]), int'(ab[0]));
            check("w1_done", {o_busy, o_done, o_g, o_l, o_eq}, {2'b01, held_o});
            w1_valid = 1'b0;
            tick();
            check("w1_idle", {o_busy, o_done, o_g, o_l, o_eq}, {2'b00, held_o});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
